fsm_download_flit: RTL

Receive-side counterpart of the upload FSM. Pops serial 16-bit flits from a ring-network local-in FIFO and reassembles them into one parallel message: head flit plus up to MAX_BODY body flits. Delivers the message to the memory side (requests) or the cache side (replies) over a valid/ack handshake. Sits between the network input FIFO and the cache/memory controllers in the communication assist.

---
 rtl/fsm_download_flit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fsm_download_flit.sv
// Receive-side flit reassembler: pops 16-bit flits from the ring local-in FIFO,
// builds head + up to MAX_BODY body flits, and hands the message to memory or cache.
module fsm_download_flit #(
  parameter int MAX_BODY = 10,
  parameter int LEN_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flit_valid,
  input  logic [15:0]              flit,
  input  logic [1:0]               flit_ctrl,
  output logic                     flit_rdy,
  output logic                     req_msg_valid,
  input  logic                     req_msg_ack,
  output logic                     rep_msg_valid,
  input  logic                     rep_msg_ack,
  output logic [15:0]              msg_head,
  output logic [16*MAX_BODY-1:0]   msg_body,
  output logic [LEN_W-1:0]         msg_len,
  output logic                     proto_err,
  output logic [1:0]               fsm_state_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ASSEMBLE = 2'b01,
    DELIVER  = 2'b10
  } state_t;

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;
  localparam logic [LEN_W-1:0] CNT_FULL = LEN_W'(MAX_BODY);

  state_t                   state_q;
  logic [LEN_W-1:0]         cnt_q;
  logic [15:0]              head_q;
  logic [16*MAX_BODY-1:0]   body_q;
  logic [LEN_W-1:0]         len_q;
  logic                     req_valid_q;
  logic                     rep_valid_q;
  logic                     err_q;
  logic                     take;
  logic                     ack_hit;

  // Valid/ack handshake: a *_msg_valid stays high with msg_* stable until the
  // matching ack is sampled high on a clock edge; the non-matching ack is ignored.
  assign flit_rdy = !rst && (state_q != DELIVER);
  assign take     = flit_valid && flit_rdy;
  assign ack_hit  = (req_valid_q && req_msg_ack) || (rep_valid_q && rep_msg_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      head_q      <= '0;
      body_q      <= '0;
      len_q       <= '0;
      req_valid_q <= 1'b0;
      rep_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            unique case (flit_ctrl)
              CTRL_HEAD: begin
                head_q  <= flit;
                body_q  <= '0;
                len_q   <= '0;
                cnt_q   <= '0;
                state_q <= ASSEMBLE;
              end
              CTRL_TAIL: begin
                head_q      <= flit;
                body_q      <= '0;
                len_q       <= '0;
                cnt_q       <= '0;
                req_valid_q <= !flit[9];
                rep_valid_q <= flit[9];
                state_q     <= DELIVER;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ASSEMBLE: begin
          if (take) begin
            unique case (flit_ctrl)
              CTRL_BODY: begin
                if (cnt_q == CNT_FULL) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  body_q[{cnt_q, 4'b0000} +: 16] <= flit;
                  cnt_q <= cnt_q + LEN_W'(1);
                end
              end
              CTRL_TAIL: begin
                if (cnt_q == CNT_FULL) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  body_q[{cnt_q, 4'b0000} +: 16] <= flit;
                  len_q       <= cnt_q + LEN_W'(1);
                  req_valid_q <= !head_q[9];
                  rep_valid_q <= head_q[9];
                  state_q     <= DELIVER;
                end
              end
              CTRL_HEAD: begin
                // A head before the tail restarts assembly on the new head.
                err_q  <= 1'b1;
                head_q <= flit;
                body_q <= '0;
                len_q  <= '0;
                cnt_q  <= '0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        DELIVER: begin
          if (ack_hit) begin
            req_valid_q <= 1'b0;
            rep_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_msg_valid = req_valid_q;
  assign rep_msg_valid = rep_valid_q;
  assign msg_head      = head_q;
  assign msg_body      = body_q;
  assign msg_len       = len_q;
  assign proto_err     = err_q;
  assign fsm_state_out = state_q;

endmodule
